robot_cmd_ctrl: RTL

Parametrised command controller between the NEC IR receiver and the motor controller and UART transmitter. It validates IR frames and maps keys to motor commands. It adds a dead-man hold timeout, a proximity interlock with hysteresis, and a periodic or on-change telemetry byte with a valid/ready handshake. It replaces the ad-hoc key decode and always-valid status byte in the robot top level.

---
 rtl/robot_pkg.sv | 58 +++++
 rtl/robot_tlm_sched.sv | 61 ++++++
 rtl/robot_cmd_ctrl.sv | 180 ++++++++++++++++++
 3 files changed

// File: rtl/robot_pkg.sv
// Shared types, encodings and key decode for the robot command path.
package robot_pkg;

    typedef enum logic [2:0] {
        NONE  = 3'd0,
        FWD   = 3'd1,
        LEFT  = 3'd2,
        BRAKE = 3'd3,
        RIGHT = 3'd4,
        BACK  = 3'd5
    } motor_stat_t;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        INHIBIT
    } ctrl_state_t;

    localparam logic [7:0] CMD_NONE  = 8'h00;
    localparam logic [7:0] CMD_FWD   = 8'h02;
    localparam logic [7:0] CMD_LEFT  = 8'h08;
    localparam logic [7:0] CMD_BRAKE = 8'h10;
    localparam logic [7:0] CMD_RIGHT = 8'h20;
    localparam logic [7:0] CMD_BACK  = 8'h80;

    localparam logic [7:0] KEY_FWD   = 8'h02;
    localparam logic [7:0] KEY_LEFT  = 8'h04;
    localparam logic [7:0] KEY_BRAKE = 8'h05;
    localparam logic [7:0] KEY_RIGHT = 8'h06;
    localparam logic [7:0] KEY_BACK  = 8'h08;

    function automatic motor_stat_t key_to_stat(input logic [7:0] key);
        motor_stat_t stat;
        case (key)
            KEY_FWD:   stat = FWD;
            KEY_LEFT:  stat = LEFT;
            KEY_BRAKE: stat = BRAKE;
            KEY_RIGHT: stat = RIGHT;
            KEY_BACK:  stat = BACK;
            default:   stat = NONE;
        endcase
        return stat;
    endfunction

    function automatic logic [7:0] stat_to_cmd(input motor_stat_t stat);
        logic [7:0] cmd;
        case (stat)
            FWD:     cmd = CMD_FWD;
            LEFT:    cmd = CMD_LEFT;
            BRAKE:   cmd = CMD_BRAKE;
            RIGHT:   cmd = CMD_RIGHT;
            BACK:    cmd = CMD_BACK;
            default: cmd = CMD_NONE;
        endcase
        return cmd;
    endfunction

endpackage

// File: rtl/robot_tlm_sched.sv
// Telemetry scheduler: periodic or on-change capture into a valid/ready holding register.
module robot_tlm_sched
    import robot_pkg::*;
#(
    parameter int TLM_PERIOD = 1_000_000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [7:0]  tlm_byte,
    input  motor_stat_t stat,
    input  logic        tlm_ready,
    output logic [7:0]  tlm_data,
    output logic        tlm_valid
);

    localparam int PER_W = (TLM_PERIOD > 2) ? $clog2(TLM_PERIOD) : 1;
    localparam logic [PER_W-1:0] PER_LAST = PER_W'(TLM_PERIOD - 1);

    logic [PER_W-1:0] per_cnt;
    motor_stat_t      stat_q;
    logic             pending;
    logic             trig;
    logic             handshake;

    assign trig      = (per_cnt == PER_LAST) || (stat != stat_q);
    assign handshake = tlm_valid & tlm_ready;

    always_ff @(posedge clk) begin
        if (rst) begin
            per_cnt <= '0;
            stat_q  <= NONE;
        end else begin
            per_cnt <= (per_cnt == PER_LAST) ? '0 : per_cnt + PER_W'(1);
            stat_q  <= stat;
        end
    end

    // A trigger seen while a byte is held is remembered and served by recapturing on the handshake.
    always_ff @(posedge clk) begin
        if (rst) begin
            tlm_data  <= '0;
            tlm_valid <= 1'b0;
            pending   <= 1'b0;
        end else if (!tlm_valid) begin
            if (trig) begin
                tlm_data  <= tlm_byte;
                tlm_valid <= 1'b1;
            end
        end else if (handshake) begin
            if (pending || trig) begin
                tlm_data <= tlm_byte;
                pending  <= 1'b0;
            end else begin
                tlm_valid <= 1'b0;
            end
        end else if (trig) begin
            pending <= 1'b1;
        end
    end

endmodule

// File: rtl/robot_cmd_ctrl.sv
// IR frame validation, key-to-motor command FSM with dead-man hold and proximity interlock.
module robot_cmd_ctrl
    import robot_pkg::*;
#(
    parameter int HOLD_CYC   = 6_000_000,
    parameter int LATCH_MODE = 0,
    parameter int PROX_W     = 8,
    parameter int PROX_STOP  = 16,
    parameter int PROX_HYST  = 4,
    parameter int TLM_PERIOD = 1_000_000
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              ir_valid,
    input  logic [31:0]       ir_data,
    input  logic [PROX_W-1:0] prox_level,
    output logic [7:0]        cmd_onehot,
    output logic [2:0]        motor_stat,
    output logic              interlock,
    output logic [7:0]        chk_err_cnt,
    output logic [7:0]        tlm_data,
    output logic              tlm_valid,
    input  logic              tlm_ready
);

    localparam int HOLD_W = $clog2(HOLD_CYC + 1);
    localparam logic [HOLD_W-1:0] HOLD_LOAD   = HOLD_W'(HOLD_CYC);
    localparam logic [PROX_W-1:0] PROX_STOP_V = PROX_W'(PROX_STOP);
    localparam logic [PROX_W-1:0] PROX_REL_V  = PROX_W'(PROX_STOP - PROX_HYST);
    localparam logic [PROX_W-1:0] PROX_SAT_V  = PROX_W'(64);
    localparam logic [PROX_W-1:0] PROX_MIN_V  = PROX_W'(4);

    logic              ir_valid_q;
    logic              new_frame;
    logic              csum_ok;
    logic              frm_ok;
    logic              frm_bad;
    motor_stat_t       frm_stat;
    ctrl_state_t       state, state_n;
    motor_stat_t       cur_stat, stat_n;
    motor_stat_t       out_stat;
    logic [HOLD_W-1:0] hold_cnt;
    logic              timeout;
    logic [3:0]        prox_nib;
    logic [7:0]        tlm_byte;
    logic              unused_frame_bits;

    assign new_frame         = ir_valid & ~ir_valid_q;
    assign csum_ok           = (ir_data[31:24] == ~ir_data[23:16]);
    assign unused_frame_bits = ^ir_data[15:0];
    assign timeout           = (LATCH_MODE == 0) && (state != IDLE) && (hold_cnt == '0);

    always_ff @(posedge clk) begin
        if (rst) begin
            ir_valid_q <= 1'b0;
            frm_ok     <= 1'b0;
            frm_bad    <= 1'b0;
            frm_stat   <= NONE;
        end else begin
            ir_valid_q <= ir_valid;
            frm_ok     <= new_frame & csum_ok;
            frm_bad    <= new_frame & ~csum_ok;
            frm_stat   <= key_to_stat(ir_data[23:16]);
        end
    end

    // Frames take priority over timeout; the forward/proximity check runs on the resulting command.
    always_comb begin
        state_n = state;
        stat_n  = cur_stat;
        case (state)
            IDLE: begin
                if (frm_ok && frm_stat != NONE) begin
                    state_n = RUN;
                    stat_n  = frm_stat;
                end
            end
            RUN: begin
                if (frm_ok) begin
                    if (frm_stat == NONE) begin
                        state_n = IDLE;
                        stat_n  = NONE;
                    end else begin
                        stat_n = frm_stat;
                    end
                end else if (timeout) begin
                    state_n = IDLE;
                    stat_n  = NONE;
                end
            end
            INHIBIT: begin
                if (frm_ok) begin
                    if (frm_stat == NONE) begin
                        state_n = IDLE;
                        stat_n  = NONE;
                    end else if (frm_stat != FWD) begin
                        state_n = RUN;
                        stat_n  = frm_stat;
                    end
                end else if (timeout) begin
                    state_n = IDLE;
                    stat_n  = NONE;
                end else if (prox_level < PROX_REL_V) begin
                    state_n = RUN;
                end
            end
            default: begin
                state_n = IDLE;
                stat_n  = NONE;
            end
        endcase
        if (state_n == RUN && stat_n == FWD && prox_level >= PROX_STOP_V) begin
            state_n = INHIBIT;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            cur_stat    <= NONE;
            hold_cnt    <= '0;
            chk_err_cnt <= '0;
        end else begin
            state    <= state_n;
            cur_stat <= stat_n;
            if (frm_ok) begin
                hold_cnt <= HOLD_LOAD;
            end else if (state != IDLE && hold_cnt != '0) begin
                hold_cnt <= hold_cnt - HOLD_W'(1);
            end
            if (frm_bad && chk_err_cnt != 8'hFF) begin
                chk_err_cnt <= chk_err_cnt + 8'd1;
            end
        end
    end

    always_comb begin
        cmd_onehot = CMD_NONE;
        out_stat   = NONE;
        interlock  = 1'b0;
        case (state)
            RUN: begin
                cmd_onehot = stat_to_cmd(cur_stat);
                out_stat   = cur_stat;
            end
            INHIBIT: begin
                cmd_onehot = CMD_BRAKE;
                out_stat   = BRAKE;
                interlock  = 1'b1;
            end
            default: ;
        endcase
    end

    assign motor_stat = out_stat;

    always_comb begin
        prox_nib = prox_level[5:2];
        if (prox_level >= PROX_SAT_V) begin
            prox_nib = 4'hF;
        end else if (prox_level < PROX_MIN_V) begin
            prox_nib = 4'h0;
        end
    end

    assign tlm_byte = {prox_nib, out_stat, 1'b1};

    robot_tlm_sched #(
        .TLM_PERIOD(TLM_PERIOD)
    ) u_tlm (
        .clk      (clk),
        .rst      (rst),
        .tlm_byte (tlm_byte),
        .stat     (out_stat),
        .tlm_ready(tlm_ready),
        .tlm_data (tlm_data),
        .tlm_valid(tlm_valid)
    );

endmodule
